// File: rtl/pipe_control_if.sv
// Handshake bundle between the ID stage and the pipelined main control unit.
// The master modport is the ID/EX side that drives the instruction; the slave is pipe_control.
interface pipe_control_if #(
  parameter int REG_ADDR_W = 5,
  parameter int OPCODE_W   = 7
);
  logic                  id_valid;
  logic [OPCODE_W-1:0]   id_opcode;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  ex_branch_taken;

  logic                  stall;
  logic                  flush;
  logic                  illegal;
  logic                  ex_valid;
  logic                  ex_alusrc;
  logic                  ex_branch;
  logic                  ex_jump;
  logic [1:0]            ex_aluop;
  logic                  mem_memread;
  logic                  mem_memwrite;
  logic                  wb_regwrite;
  logic                  wb_memtoreg;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;

  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_branch_taken,
    input  stall, flush, illegal, ex_valid, ex_alusrc, ex_branch, ex_jump, ex_aluop,
           mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg, wb_rd, fwd_a, fwd_b
  );

  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_branch_taken,
    output stall, flush, illegal, ex_valid, ex_alusrc, ex_branch, ex_jump, ex_aluop,
           mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg, wb_rd, fwd_a, fwd_b
  );
endinterface

// File: rtl/pipe_control.sv
// Main control unit: opcode decode, ID/EX..MEM/WB control pipeline, hazard stall/flush.
// Define PIPE_CONTROL_FORWARD_EN to build the forwarding unit (load-use-only stalls).
module pipe_control #(
  parameter int REG_ADDR_W = 5,
  parameter int OPCODE_W   = 7
) (
  input logic           clk,
  input logic           rst,
  pipe_control_if.slave pc
);

  localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       alusrc;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       branch;
    logic       jump;
    logic [1:0] aluop;
  } ctrl_t;

  ctrl_t                 id_ctrl;
  logic                  id_known;
  logic                  use_rs1;
  logic                  use_rs2;

  ctrl_t                 ex_q;
  logic [REG_ADDR_W-1:0] ex_rd_q;
  logic                  mem_valid_q;
  logic                  mem_regwrite_q;
  logic                  mem_memread_q;
  logic                  mem_memwrite_q;
  logic                  mem_memtoreg_q;
  logic [REG_ADDR_W-1:0] mem_rd_q;
  logic                  wb_regwrite_q;
  logic                  wb_memtoreg_q;
  logic [REG_ADDR_W-1:0] wb_rd_q;

  logic                  hit_ex;
  logic                  hazard;
  logic                  flush_c;
  logic                  stall_c;

  function automatic logic rd_hit(input logic v, input logic rw,
                                  input logic [REG_ADDR_W-1:0] rd,
                                  input logic [REG_ADDR_W-1:0] rs);
    return v & rw & (rd != '0) & (rd == rs);
  endfunction

  always_comb begin
    id_ctrl  = '0;
    id_known = 1'b1;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    case (pc.id_opcode)
      OP_R: begin
        id_ctrl.regwrite = 1'b1;
        id_ctrl.aluop    = 2'b10;
        use_rs1          = 1'b1;
        use_rs2          = 1'b1;
      end
      OP_I: begin
        id_ctrl.regwrite = 1'b1;
        id_ctrl.alusrc   = 1'b1;
        id_ctrl.aluop    = 2'b11;
        use_rs1          = 1'b1;
      end
      OP_LOAD: begin
        id_ctrl.regwrite = 1'b1;
        id_ctrl.alusrc   = 1'b1;
        id_ctrl.memread  = 1'b1;
        id_ctrl.memtoreg = 1'b1;
        use_rs1          = 1'b1;
      end
      OP_STORE: begin
        id_ctrl.alusrc   = 1'b1;
        id_ctrl.memwrite = 1'b1;
        use_rs1          = 1'b1;
        use_rs2          = 1'b1;
      end
      OP_BRANCH: begin
        id_ctrl.branch   = 1'b1;
        id_ctrl.aluop    = 2'b01;
        use_rs1          = 1'b1;
        use_rs2          = 1'b1;
      end
      OP_JAL: begin
        id_ctrl.jump     = 1'b1;
        id_ctrl.regwrite = 1'b1;
      end
      OP_JALR: begin
        id_ctrl.jump     = 1'b1;
        id_ctrl.regwrite = 1'b1;
        id_ctrl.alusrc   = 1'b1;
        use_rs1          = 1'b1;
      end
      default: id_known = 1'b0;
    endcase
    // An invalid or unknown instruction must enter EX as a clean bubble.
    if (!(pc.id_valid && id_known)) begin
      id_ctrl = '0;
    end else begin
      id_ctrl.valid = 1'b1;
    end
  end

  assign hit_ex = (use_rs1 & rd_hit(ex_q.valid, ex_q.regwrite, ex_rd_q, pc.id_rs1)) |
                  (use_rs2 & rd_hit(ex_q.valid, ex_q.regwrite, ex_rd_q, pc.id_rs2));

`ifdef PIPE_CONTROL_FORWARD_EN
  assign hazard = id_ctrl.valid & ex_q.memread & hit_ex;
`else
  logic hit_mem;
  assign hit_mem = (use_rs1 & rd_hit(mem_valid_q, mem_regwrite_q, mem_rd_q, pc.id_rs1)) |
                   (use_rs2 & rd_hit(mem_valid_q, mem_regwrite_q, mem_rd_q, pc.id_rs2));
  assign hazard  = id_ctrl.valid & (hit_ex | hit_mem);
`endif

  // A taken branch kills the ID instruction, so its hazard is moot.
  assign flush_c = ex_q.valid & pc.ex_branch_taken;
  assign stall_c = hazard & ~flush_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q           <= '0;
      ex_rd_q        <= '0;
      mem_valid_q    <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_memread_q  <= 1'b0;
      mem_memwrite_q <= 1'b0;
      mem_memtoreg_q <= 1'b0;
      mem_rd_q       <= '0;
      wb_regwrite_q  <= 1'b0;
      wb_memtoreg_q  <= 1'b0;
      wb_rd_q        <= '0;
    end else begin
      if (stall_c || flush_c) begin
        ex_q    <= '0;
        ex_rd_q <= '0;
      end else begin
        ex_q    <= id_ctrl;
        ex_rd_q <= id_ctrl.valid ? pc.id_rd : '0;
      end
      mem_valid_q    <= ex_q.valid;
      mem_regwrite_q <= ex_q.regwrite;
      mem_memread_q  <= ex_q.memread;
      mem_memwrite_q <= ex_q.memwrite;
      mem_memtoreg_q <= ex_q.memtoreg;
      mem_rd_q       <= ex_rd_q;
      wb_regwrite_q  <= mem_regwrite_q;
      wb_memtoreg_q  <= mem_memtoreg_q;
      wb_rd_q        <= mem_rd_q;
    end
  end

`ifdef PIPE_CONTROL_FORWARD_EN
  logic [REG_ADDR_W-1:0] ex_rs1_q;
  logic [REG_ADDR_W-1:0] ex_rs2_q;
  logic                  wb_valid_q;
  logic [1:0]            fwd_a_c;
  logic [1:0]            fwd_b_c;

  // Unused source fields are stored as x0 so they can never match a producer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      wb_valid_q <= 1'b0;
    end else begin
      if (stall_c || flush_c || !id_ctrl.valid) begin
        ex_rs1_q <= '0;
        ex_rs2_q <= '0;
      end else begin
        ex_rs1_q <= use_rs1 ? pc.id_rs1 : '0;
        ex_rs2_q <= use_rs2 ? pc.id_rs2 : '0;
      end
      wb_valid_q <= mem_valid_q;
    end
  end

  always_comb begin
    fwd_a_c = 2'b00;
    fwd_b_c = 2'b00;
    if (ex_q.valid) begin
      if (rd_hit(mem_valid_q, mem_regwrite_q, mem_rd_q, ex_rs1_q))
        fwd_a_c = 2'b10;
      else if (rd_hit(wb_valid_q, wb_regwrite_q, wb_rd_q, ex_rs1_q))
        fwd_a_c = 2'b01;
      if (rd_hit(mem_valid_q, mem_regwrite_q, mem_rd_q, ex_rs2_q))
        fwd_b_c = 2'b10;
      else if (rd_hit(wb_valid_q, wb_regwrite_q, wb_rd_q, ex_rs2_q))
        fwd_b_c = 2'b01;
    end
  end

  assign pc.fwd_a = fwd_a_c;
  assign pc.fwd_b = fwd_b_c;
`else
  assign pc.fwd_a = 2'b00;
  assign pc.fwd_b = 2'b00;
`endif

  assign pc.stall        = stall_c;
  assign pc.flush        = flush_c;
  assign pc.illegal      = pc.id_valid & ~id_known;
  assign pc.ex_valid     = ex_q.valid;
  assign pc.ex_alusrc    = ex_q.alusrc;
  assign pc.ex_branch    = ex_q.branch;
  assign pc.ex_jump      = ex_q.jump;
  assign pc.ex_aluop     = ex_q.aluop;
  assign pc.mem_memread  = mem_memread_q;
  assign pc.mem_memwrite = mem_memwrite_q;
  assign pc.wb_regwrite  = wb_regwrite_q;
  assign pc.wb_memtoreg  = wb_memtoreg_q;
  assign pc.wb_rd        = wb_rd_q;

endmodule
